// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: lock-qualified reset generator in the pll_clk domain.
// Synchronises the raw PLL locked flag, waits for HOLD_CYCLES consecutive
// lock samples before releasing sys_rst_n, and re-asserts it on any loss.
//
// Optional feature macro: PLL_RESET_CTRL_LOSS_CNT_EN
//   defined   -> loss_count is a live saturating count of lock losses
//   undefined -> loss_count is tied to zero (lock_lost still works)
//
// Note: if pll_clk stops, this block cannot assert sys_rst_n by itself;
// the top level also combines rst_n into the downstream reset.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no lock seen; reset held, hold counter cleared
// HOLD  | lock seen; counting consecutive lock samples
// RUN   | lock qualified; reset released, ready high
module pll_reset_ctrl #(
  parameter int HOLD_CYCLES = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             pll_clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             clear_sticky,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count
);

  localparam int HCW = $clog2(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [HCW-1:0]         hold_cnt;
  logic                   hold_done;
  logic                   loss_event;

  assign lock_s     = sync_q[SYNC_STAGES-1];
  assign hold_done  = (hold_cnt == HOLD_LAST);
  assign loss_event = (state == RUN) && !lock_s;

  // Multi-flop synchroniser for the asynchronous locked flag
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // State register
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; any low lock sample outside IDLE drops back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (lock_s) next_state = HOLD;
      HOLD: begin
        if (!lock_s) begin
          next_state = IDLE;
        end else if (hold_done) begin
          next_state = RUN;
        end
      end
      RUN:  if (!lock_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Hold counter only advances while staying in HOLD, so every abort restarts at zero
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((state == HOLD) && (next_state == HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Registered reset and ready, driven from next_state so they change with the state
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      sys_rst_n <= (next_state == RUN);
      ready     <= (next_state == RUN);
    end
  end

  // Sticky loss flag; a loss in the same cycle as clear_sticky keeps it set
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost <= 1'b0;
    end else if (loss_event) begin
      lock_lost <= 1'b1;
    end else if (clear_sticky) begin
      lock_lost <= 1'b0;
    end
  end

`ifdef PLL_RESET_CTRL_LOSS_CNT_EN
  // Saturating loss counter, cleared only by rst_n
  always_ff @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count <= '0;
    end else if (loss_event && (loss_count != {CNT_W{1'b1}})) begin
      loss_count <= loss_count + 1'b1;
    end
  end
`else
  assign loss_count = '0;
`endif

endmodule
